// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the iterative inverse cipher.
// Holds the forward/inverse S-boxes, the key-schedule round constants,
// GF(2^8) helpers (polynomial 0x11B) and the controller state encoding.
// Byte 0 of any 128-bit block sits in bits [127:120] (FIPS-197 order).
package aes_pkg;

  typedef enum logic [1:0] {IDLE, KEXP, ROUND, DONE} fsm_t;

  // Entry 0 is the most significant byte of each table.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  localparam logic [1:10][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Shift-and-add multiply; with constant b most terms fold away.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_128_decrypt_iter_if.sv
// Handshake bundle of the iterative AES-128 decryptor.
//   in_valid/in_ready   : ciphertext + key transfer into the block
//   ciphertext, key     : 128-bit operands, byte 0 in bits [127:120]
//   out_valid/out_ready : plaintext transfer out of the block
//   plaintext           : result, stable while out_valid is high
// master = producer/consumer side, slave = the decryptor.
interface aes_128_decrypt_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] ciphertext;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] plaintext;

  modport master (
    output in_valid, ciphertext, key, out_ready,
    input  in_ready, out_valid, plaintext
  );

  modport slave (
    input  in_valid, ciphertext, key, out_ready,
    output in_ready, out_valid, plaintext
  );
endinterface

// File: rtl/aes_inv_round_logic.sv
// One combinational AES inverse round.
//   state_in  : current state
//   round_key : key added after the substitution step
//   is_final  : skip InvMixColumns (last round)
//   state_out : InvMixColumns(InvSubBytes(InvShiftRows(state_in)) ^ round_key)
module aes_inv_round_logic
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         is_final,
  output logic [127:0] state_out
);
  logic [127:0] added;
  logic [127:0] mixed;

  // Byte gi is row gi%4, column gi/4. InvShiftRows moves row r right by r,
  // so output column c takes its byte from input column (c - r) mod 4.
  for (genvar gi = 0; gi < 16; gi++) begin : g_byte
    localparam int SRC = 4 * ((gi / 4 - gi % 4 + 4) % 4) + gi % 4;
    assign added[127-8*gi -: 8] = INV_SBOX[state_in[127-8*SRC -: 8]] ^ round_key[127-8*gi -: 8];
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = added[127-32*gi -: 8];
    assign a1 = added[119-32*gi -: 8];
    assign a2 = added[111-32*gi -: 8];
    assign a3 = added[103-32*gi -: 8];
    assign mixed[127-32*gi -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
    assign mixed[119-32*gi -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
    assign mixed[111-32*gi -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
    assign mixed[103-32*gi -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
  end

  assign state_out = is_final ? added : mixed;
endmodule

// File: rtl/aes_128_decrypt_iter.sv
// Iterative AES-128 inverse cipher, one inverse round per clock.
// Ports: clk, rst (synchronous, active high) and bus (slave side of
// aes_128_decrypt_iter_if: in_valid/in_ready/ciphertext/key in,
// out_valid/out_ready/plaintext out).
// The round keys are expanded on chip into an 11-entry register file and
// the last key is remembered, so a block under the same key starts the
// inverse rounds immediately (KEY_CACHE=1). A different key re-expands.
module aes_128_decrypt_iter
  import aes_pkg::*;
#(
  parameter bit KEY_CACHE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  aes_128_decrypt_iter_if.slave bus
);
  fsm_t         fsm_reg;
  logic [127:0] rk_reg [11];
  logic [127:0] st_reg;
  logic [127:0] cached_key_reg;
  logic [127:0] plaintext_reg;
  logic         cache_valid_reg;
  logic         out_valid_reg;
  logic [3:0]   cnt_reg;

  logic         accept;
  logic         key_hit;
  logic [127:0] rk_prev;
  logic [31:0]  temp_word;
  logic [31:0]  w0_next, w1_next, w2_next, w3_next;
  logic [127:0] rk_next;
  logic [127:0] round_out;

  assign bus.in_ready  = (fsm_reg == IDLE);
  assign bus.out_valid = out_valid_reg;
  assign bus.plaintext = plaintext_reg;

  assign accept  = bus.in_valid && (fsm_reg == IDLE);
  assign key_hit = KEY_CACHE && cache_valid_reg && (bus.key == cached_key_reg);

  // One key-schedule step: rk[cnt] derived from rk[cnt-1].
  always_comb begin
    rk_prev   = rk_reg[cnt_reg - 4'd1];
    temp_word = sub_word(rot_word(rk_prev[31:0])) ^ {RCON[cnt_reg], 24'h000000};
    w0_next   = rk_prev[127:96] ^ temp_word;
    w1_next   = rk_prev[95:64] ^ w0_next;
    w2_next   = rk_prev[63:32] ^ w1_next;
    w3_next   = rk_prev[31:0] ^ w2_next;
    rk_next   = {w0_next, w1_next, w2_next, w3_next};
  end

  aes_inv_round_logic u_round (
    .state_in  (st_reg),
    .round_key (rk_reg[cnt_reg]),
    .is_final  (cnt_reg == 4'd0),
    .state_out (round_out)
  );

  // The round-key file is deliberately left out of reset: the cache is
  // invalidated instead, which forces re-expansion before any reuse.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_reg         <= IDLE;
      out_valid_reg   <= 1'b0;
      plaintext_reg   <= '0;
      cache_valid_reg <= 1'b0;
      cnt_reg         <= 4'd0;
      st_reg          <= '0;
    end else begin
      case (fsm_reg)
        IDLE: begin
          if (accept) begin
            if (key_hit) begin
              st_reg  <= bus.ciphertext ^ rk_reg[10];
              cnt_reg <= 4'd9;
              fsm_reg <= ROUND;
            end else begin
              rk_reg[0]       <= bus.key;
              cached_key_reg  <= bus.key;
              cache_valid_reg <= 1'b0;
              st_reg          <= bus.ciphertext;
              cnt_reg         <= 4'd1;
              fsm_reg         <= KEXP;
            end
          end
        end
        KEXP: begin
          rk_reg[cnt_reg] <= rk_next;
          if (cnt_reg == 4'd10) begin
            // Initial AddRoundKey folded into the last expansion step.
            st_reg          <= st_reg ^ rk_next;
            cache_valid_reg <= 1'b1;
            cnt_reg         <= 4'd9;
            fsm_reg         <= ROUND;
          end else begin
            cnt_reg <= cnt_reg + 4'd1;
          end
        end
        ROUND: begin
          if (cnt_reg == 4'd0) begin
            plaintext_reg <= round_out;
            out_valid_reg <= 1'b1;
            fsm_reg       <= DONE;
          end else begin
            st_reg  <= round_out;
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            fsm_reg       <= IDLE;
          end
        end
        default: fsm_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_128_decrypt_iter.sv
// Scoreboard bench for aes_128_decrypt_iter. dut0 caches keys, dut1 does
// not. The driver pushes the expected plaintext and latency when it issues
// a block; the monitor pops and compares when out_valid first rises.
// Latency counts clock edges from the accept edge (inclusive) to the edge
// that raises out_valid.
`timescale 1ns/1ps
module tb_aes_128_decrypt_iter;
  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  aes_128_decrypt_iter_if bus0 ();
  aes_128_decrypt_iter_if bus1 ();

  aes_128_decrypt_iter #(.KEY_CACHE(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  aes_128_decrypt_iter #(.KEY_CACHE(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct packed {
    logic [127:0] pt;
    int           lat;
    int           acc_cyc;
  } exp_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  int   xfer0 = 0;
  int   xfer1 = 0;
  bit   seen0 = 1'b0;
  bit   seen1 = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Output handshakes complete on the rising edge; count them there.
  always @(posedge clk) begin
    if (!rst && bus0.out_valid && bus0.out_ready) begin xfer0++; seen0 = 1'b0; end
    if (!rst && bus1.out_valid && bus1.out_ready) begin xfer1++; seen1 = 1'b0; end
    if (rst) begin seen0 = 1'b0; seen1 = 1'b0; end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus0.out_valid && !seen0) begin
        seen0 = 1'b1;
        if (exp_q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL dut0_unexpected_output: got %0h, expected no output", bus0.plaintext);
        end else begin
          e = exp_q0.pop_front();
          check("dut0_plaintext", bus0.plaintext, e.pt);
          check("dut0_latency", 128'(cyc - e.acc_cyc + 1), 128'(e.lat));
        end
      end
      if (bus1.out_valid && !seen1) begin
        seen1 = 1'b1;
        if (exp_q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL dut1_unexpected_output: got %0h, expected no output", bus1.plaintext);
        end else begin
          e = exp_q1.pop_front();
          check("dut1_plaintext", bus1.plaintext, e.pt);
          check("dut1_latency", 128'(cyc - e.acc_cyc + 1), 128'(e.lat));
        end
      end
    end
  end

  // Called on a falling edge; returns on the falling edge after the accept.
  task automatic send(input int sel, input logic [127:0] k, input logic [127:0] c,
                      input logic [127:0] p, input int lat, input bit expect_out);
    int   waited;
    exp_t e;
    waited = 0;
    while (((sel == 0) ? bus0.in_ready : bus1.in_ready) !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) begin
      checks++; errors++;
      $display("FAIL send_timeout: dut%0d in_ready low for %0d cycles, expected high", sel, waited);
      return;
    end
    e.pt = p; e.lat = lat; e.acc_cyc = cyc + 1;
    if (sel == 0) begin
      bus0.key = k; bus0.ciphertext = c; bus0.in_valid = 1'b1;
      if (expect_out) exp_q0.push_back(e);
    end else begin
      bus1.key = k; bus1.ciphertext = c; bus1.in_valid = 1'b1;
      if (expect_out) exp_q1.push_back(e);
    end
    @(negedge clk);
    if (sel == 0) bus0.in_valid = 1'b0;
    else          bus1.in_valid = 1'b0;
  endtask

  task automatic wait_done(input int sel);
    int n;
    n = 0;
    while (n < 100 && ((sel == 0) ? (exp_q0.size() != 0 || bus0.out_valid)
                                  : (exp_q1.size() != 0 || bus1.out_valid))) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL wait_done_timeout: dut%0d busy after %0d cycles, expected idle", sel, n);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int xfer_before;
    rst = 1'b1;
    bus0.in_valid = 1'b0; bus0.key = '0; bus0.ciphertext = '0; bus0.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.key = '0; bus1.ciphertext = '0; bus1.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_dut0_in_ready", 128'(bus0.in_ready), 128'(1));
    check("reset_dut0_out_valid", 128'(bus0.out_valid), 128'(0));
    check("reset_dut0_plaintext", bus0.plaintext, 128'h0);
    check("reset_dut1_in_ready", 128'(bus1.in_ready), 128'(1));
    check("reset_dut1_out_valid", 128'(bus1.out_valid), 128'(0));
    rst = 1'b0;
    @(negedge clk);

    // Miss, hit, then a different key evicts the cached one.
    send(0, K1, C1, P1, 21, 1'b1); wait_done(0);
    send(0, K1, C1, P1, 11, 1'b1); wait_done(0);
    send(0, K2, C2, P2, 21, 1'b1); wait_done(0);

    // Back-pressure with stray in_valid pulses that must be ignored.
    bus0.out_ready = 1'b0;
    send(0, K2, C2, P2, 11, 1'b1);
    n = 0;
    while (!bus0.out_valid && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL hold_wait_timeout: out_valid low for %0d cycles, expected high", n);
    end
    for (int i = 0; i < 50; i++) begin
      check("hold_plaintext", bus0.plaintext, P2);
      check("hold_out_valid", 128'(bus0.out_valid), 128'(1));
      check("hold_in_ready", 128'(bus0.in_ready), 128'(0));
      bus0.key = K1; bus0.ciphertext = C1; bus0.in_valid = (i % 2 == 0);
      @(negedge clk);
    end
    bus0.in_valid = 1'b0;
    xfer_before = xfer0;
    bus0.out_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("release_transfers", 128'(xfer0 - xfer_before), 128'(1));
    check("release_out_valid", 128'(bus0.out_valid), 128'(0));
    check("release_in_ready", 128'(bus0.in_ready), 128'(1));

    // Abort a miss during key expansion (edge of KEXP cycle 5).
    send(0, K1, C1, P1, 21, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_in_ready", 128'(bus0.in_ready), 128'(1));
    check("abort_out_valid", 128'(bus0.out_valid), 128'(0));
    check("abort_plaintext", bus0.plaintext, 128'h0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("abort_no_output", 128'(bus0.out_valid), 128'(0));
    send(0, K1, C1, P1, 21, 1'b1); wait_done(0);

    // Non-caching build: same key twice back to back, both full latency.
    send(1, K1, C1, P1, 21, 1'b1);
    send(1, K1, C1, P1, 21, 1'b1);
    wait_done(1);
    send(1, K2, C2, P2, 21, 1'b1); wait_done(1);

    repeat (3) @(negedge clk);
    check("dut0_queue_empty", 128'(exp_q0.size()), 128'(0));
    check("dut1_queue_empty", 128'(exp_q1.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
